// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad front-end.
//   kp_state_t : encoder FSM states
//   KEY_W      : width of the key index carried on key_code
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam int KEY_W = 4;

endpackage

// File: rtl/keypad_encoder_pb_sync.sv
// pb_sync: two-flop synchronizer for a bus of independent asynchronous bits.
//   CLK   in   1      sampling clock
//   NRST  in   1      asynchronous active-low reset, clears both stages to 0
//   d     in   WIDTH  asynchronous inputs
//   q     out  WIDTH  inputs delayed by two CLK edges
module pb_sync #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: synchronizes and debounces the push-button keypad, resolves
// simultaneous presses to the lowest index, and emits one single-cycle event
// per physical press.
//   CLK        in   1         system clock
//   NRST       in   1         asynchronous active-low reset
//   pb         in   NUM_KEYS  raw asynchronous buttons, active-high
//   key_valid  out  1         one-cycle strobe when a debounced press is accepted
//   key_code   out  KEY_W     index of the accepted key, held until the next accept
//   key_onehot out  NUM_KEYS  one-hot of key_code while key_valid=1, else zero
//   key_held   out  1         high while the accepted key is pressed or releasing
//   fsm_state  out  2         current FSM state, for observation only
//
// Handshake: key_valid is a pure strobe with no ready; a consumer must take
// key_code/key_onehot in the cycle key_valid is high. At most one strobe is
// produced per IDLE->PRESSED pass.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = 16,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                NRST,
  input  logic [NUM_KEYS-1:0] pb,
  output logic                key_valid,
  output logic [KEY_W-1:0]    key_code,
  output logic [NUM_KEYS-1:0] key_onehot,
  output logic                key_held,
  output kp_state_t           fsm_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  // Lowest set index wins; scanning downward lets the last hit overwrite.
  function automatic logic [KEY_W-1:0] enc_lowest(input logic [NUM_KEYS-1:0] v);
    enc_lowest = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) enc_lowest = KEY_W'(i);
    end
  endfunction

  logic [NUM_KEYS-1:0] s;
  logic                s_any;
  logic [KEY_W-1:0]    enc;

  kp_state_t        state, state_nxt;
  logic [KEY_W-1:0] cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             fire;
  logic [KEY_W-1:0] fire_code;

  pb_sync #(.WIDTH(NUM_KEYS)) u_sync (
    .CLK (CLK),
    .NRST(NRST),
    .d   (pb),
    .q   (s)
  );

  assign s_any     = |s;
  assign enc       = enc_lowest(s);
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    fire_code = cand;
    case (state)
      IDLE: begin
        if (s_any) begin
          cand_nxt = enc;
          cnt_nxt  = CNT_ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = PRESSED;
            fire      = 1'b1;
            fire_code = enc;
          end else begin
            state_nxt = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (!s_any) begin
          state_nxt = IDLE;
        end else if (enc != cand) begin
          // A different (lower or replacing) key restarts the debounce window.
          cand_nxt = enc;
          cnt_nxt  = CNT_ONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          fire      = 1'b1;
          fire_code = cand;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        // Other keys are ignored here; only an all-released sample matters.
        if (!s_any) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        if (s_any) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_onehot <= '0;
      key_held   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      key_valid  <= fire;
      key_onehot <= fire ? (NUM_KEYS'(1) << fire_code) : '0;
      if (fire) key_code <= fire_code;
      key_held   <= (state_nxt == PRESSED) || (state_nxt == RELEASE);
    end
  end

endmodule
